// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: major opcodes (common with the control
// decoder), descriptor class codes, encoder FSM state codes and a small
// sign-extension range helper.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_IALU   = 4'd1;
  localparam logic [3:0] CLS_LW     = 4'd2;
  localparam logic [3:0] CLS_SW     = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] word;
    logic        legal;
  } enc_t;

  // True when v is the sign extension of its low msb+1 bits, i.e. bits
  // 31..msb are all equal.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational packer: one instruction descriptor -> RV32I word plus a
// legality flag covering the class code and the immediate range rules.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output enc_t        enc
);

  logic fits_i;
  logic fits_b;
  logic fits_j;
  logic is_shift;

  assign fits_i   = sext_fits(imm, 11);
  assign fits_b   = sext_fits(imm, 12) && !imm[0];
  assign fits_j   = sext_fits(imm, 20) && !imm[0];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Field packing per instruction format; unknown classes encode to zero.
  always_comb begin
    enc.word  = '0;
    enc.legal = 1'b0;
    case (op)
      CLS_R: begin
        enc.word  = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
        enc.legal = 1'b1;
      end
      CLS_IALU: begin
        if (is_shift) begin
          enc.word  = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
          enc.legal = fits_i && (imm[11:5] == 7'd0);
        end else begin
          enc.word  = {imm[11:0], rs1, funct3, rd, OP_IMM};
          enc.legal = fits_i;
        end
      end
      CLS_LW: begin
        enc.word  = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        enc.legal = fits_i;
      end
      CLS_SW: begin
        enc.word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
        enc.legal = fits_i;
      end
      CLS_BRANCH: begin
        enc.word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        enc.legal = fits_b;
      end
      CLS_JAL: begin
        enc.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        enc.legal = fits_j;
      end
      CLS_JALR: begin
        enc.word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        enc.legal = fits_i;
      end
      CLS_LUI: begin
        enc.word  = {imm[31:12], rd, OP_LUI};
        enc.legal = 1'b1;
      end
      CLS_AUIPC: begin
        enc.word  = {imm[31:12], rd, OP_AUIPC};
        enc.legal = 1'b1;
      end
      default: begin
        enc.word  = '0;
        enc.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// Streaming RV32I encoder / instruction-memory loader.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | after reset; nothing accepted until start
//   RUN     | accepting descriptors and writing encoded words
//   DONE    | last descriptor consumed and its write (if any) retired
//
// The output register holds exactly one word; im_addr is both the address
// of the pending word and the next free slot, so it only moves on a
// completed write.
module rv32i_inst_encoder
  import rv32i_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrapped,
  output logic [ADDR_W-1:0] inst_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [1:0]        state;
  logic              last_seen;
  enc_t              enc;
  logic              accept;
  logic              wr_done;
  logic              pend_next;
  logic              last_next;
  logic [ADDR_W-1:0] addr_next;

  rv32i_imm_pack u_pack (
    .op     (in_op),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .f7b5   (in_f7b5),
    .imm    (in_imm),
    .enc    (enc)
  );

  // No skid buffer: ready follows im_ready combinationally when a word is held.
  assign in_ready  = (state == ST_RUN) && !last_seen && (!im_we || im_ready);
  assign accept    = in_valid && in_ready;
  assign wr_done   = im_we && im_ready;
  assign pend_next = (im_we && !im_ready) || (accept && enc.legal);
  assign last_next = last_seen || (accept && in_last);
  assign addr_next = im_addr + STEP;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  // Sequencing: finish once the last descriptor is in and nothing is left to write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_seen <= 1'b0;
    end else if (start) begin
      state     <= ST_RUN;
      last_seen <= 1'b0;
    end else if (state == ST_RUN) begin
      if (accept && in_last) last_seen <= 1'b1;
      if (last_next && !pend_next) state <= ST_DONE;
    end
  end

  // Output register: reloads on accept even in the cycle its previous word retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we    <= 1'b0;
      im_wdata <= '0;
    end else if (start) begin
      im_we    <= 1'b0;
    end else if (accept && enc.legal) begin
      im_we    <= 1'b1;
      im_wdata <= enc.word;
    end else if (wr_done) begin
      im_we    <= 1'b0;
    end
  end

  // Address and word count advance only on a completed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_addr    <= BASE;
      inst_count <= '0;
      wrapped    <= 1'b0;
    end else if (start) begin
      im_addr    <= BASE;
      inst_count <= '0;
      wrapped    <= 1'b0;
    end else if (wr_done) begin
      im_addr <= addr_next;
      if (addr_next == '0) wrapped <= 1'b1;
      if (inst_count != '1) inst_count <= inst_count + ONE;
    end
  end

  // Sticky reject flag: illegal class or out-of-range immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (accept && !enc.legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Bench for rv32i_inst_encoder: two instances (10-bit and 4-bit address)
// share one stimulus stream; a transaction-level model predicts every
// output each cycle, and directed sequences pin known encodings.
module tb_rv32i_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_f7b5 = 1'b0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        im_ready;

  logic        in_ready_a, im_we_a, busy_a, done_a, err_a, wrapped_a;
  logic [9:0]  im_addr_a, inst_count_a;
  logic [31:0] im_wdata_a;
  logic        in_ready_b, im_we_b, busy_b, done_b, err_b, wrapped_b;
  logic [3:0]  im_addr_b, inst_count_b;
  logic [31:0] im_wdata_b;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  bit stall_en = 1'b0;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last), .im_we(im_we_a), .im_ready(im_ready),
    .im_addr(im_addr_a), .im_wdata(im_wdata_a), .busy(busy_a), .done(done_a), .err(err_a),
    .wrapped(wrapped_a), .inst_count(inst_count_a));

  rv32i_inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last), .im_we(im_we_b), .im_ready(im_ready),
    .im_addr(im_addr_b), .im_wdata(im_wdata_b), .busy(busy_b), .done(done_b), .err(err_b),
    .wrapped(wrapped_b), .inst_count(inst_count_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int v, input int p);
    return 32'(v) << p;
  endfunction

  // Reference encoder from the instruction-format tables; returns {legal, word}.
  function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                          input int f3, input int f7b5, input logic [31:0] imm);
    int s;
    logic [31:0] w;
    bit ok;
    s  = $signed(imm);
    w  = '0;
    ok = 1'b0;
    case (op)
      0: begin
        w  = fld(f7b5, 30) | fld(rs2, 20) | fld(rs1, 15) | fld(f3, 12) | fld(rd, 7) | 32'h33;
        ok = 1'b1;
      end
      1: begin
        ok = (s >= -2048) && (s <= 2047);
        if (f3 == 1 || f3 == 5) begin
          ok = ok && (s >= 0) && (s <= 31);
          w  = fld(f7b5, 30) | fld(s & 31, 20) | fld(rs1, 15) | fld(f3, 12) | fld(rd, 7) | 32'h13;
        end else begin
          w  = fld(s & 'hfff, 20) | fld(rs1, 15) | fld(f3, 12) | fld(rd, 7) | 32'h13;
        end
      end
      2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = fld(s & 'hfff, 20) | fld(rs1, 15) | fld(2, 12) | fld(rd, 7) | 32'h03;
      end
      3: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = fld((s >> 5) & 'h7f, 25) | fld(rs2, 20) | fld(rs1, 15) | fld(2, 12) | fld(s & 31, 7) | 32'h23;
      end
      4: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w  = fld((s >> 12) & 1, 31) | fld((s >> 5) & 'h3f, 25) | fld(rs2, 20) | fld(rs1, 15) |
             fld(f3, 12) | fld((s >> 1) & 'hf, 8) | fld((s >> 11) & 1, 7) | 32'h63;
      end
      5: begin
        ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
        w  = fld((s >> 20) & 1, 31) | fld((s >> 1) & 'h3ff, 21) | fld((s >> 11) & 1, 20) |
             fld((s >> 12) & 'hff, 12) | fld(rd, 7) | 32'h6f;
      end
      6: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = fld(s & 'hfff, 20) | fld(rs1, 15) | fld(rd, 7) | 32'h67;
      end
      7, 8: begin
        ok = 1'b1;
        w  = (imm & 32'hFFFF_F000) | fld(rd, 7) | ((op == 7) ? 32'h37 : 32'h17);
      end
      default: begin
        ok = 1'b0;
        w  = '0;
      end
    endcase
    return {ok, w};
  endfunction

  typedef struct {
    int          a10;
    int          a4;
    logic [31:0] w;
  } wr_t;

  wr_t         log_q[$];
  logic [31:0] exp_q[$];
  bit          m_run = 0, m_done = 0, m_last = 0, m_err = 0, m_wrap10 = 0, m_wrap4 = 0;
  int          m_a10 = 0, m_a4 = 0, m_cnt = 0;

  // Memory side: always ready, randomly ready, or held off by stall_en.
  initial begin
    im_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      im_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : !stall_en;
    end
  end

  // Transaction-level model, updated at each edge from pre-edge values.
  initial begin
    logic [32:0] r;
    bit rdy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_run = 0; m_done = 0; m_last = 0; m_err = 0; m_wrap10 = 0; m_wrap4 = 0;
        m_a10 = 0; m_a4 = 0; m_cnt = 0;
        exp_q.delete();
      end else if (start) begin
        m_run = 1; m_done = 0; m_last = 0; m_err = 0; m_wrap10 = 0; m_wrap4 = 0;
        m_a10 = 0; m_a4 = 0; m_cnt = 0;
        exp_q.delete();
        log_q.delete();
      end else if (m_run) begin
        rdy = !m_last && (exp_q.size() == 0 || im_ready);
        if (exp_q.size() != 0 && im_ready) begin
          log_q.push_back('{a10: int'(im_addr_a), a4: int'(im_addr_b), w: im_wdata_a});
          void'(exp_q.pop_front());
          m_cnt++;
          m_a10 = (m_a10 + 4) % 1024;
          if (m_a10 == 0) m_wrap10 = 1;
          m_a4 = (m_a4 + 4) % 16;
          if (m_a4 == 0) m_wrap4 = 1;
        end
        if (in_valid && rdy) begin
          r = ref_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_funct3),
                      int'(in_f7b5), in_imm);
          if (r[32]) exp_q.push_back(r[31:0]);
          else m_err = 1;
          if (in_last) m_last = 1;
        end
        if (m_last && exp_q.size() == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    bit exp_rdy;
    bit exp_we;
    forever begin
      @(negedge clk);
      exp_we  = (exp_q.size() != 0);
      exp_rdy = m_run && !m_last && (!exp_we || im_ready);
      chk("in_ready", 32'(in_ready_a), 32'(exp_rdy));
      chk("in_ready_w4", 32'(in_ready_b), 32'(exp_rdy));
      chk("im_we", 32'(im_we_a), 32'(exp_we));
      chk("im_we_w4", 32'(im_we_b), 32'(exp_we));
      chk("busy", 32'(busy_a), 32'(m_run));
      chk("done", 32'(done_a), 32'(m_done));
      chk("done_w4", 32'(done_b), 32'(m_done));
      chk("err", 32'(err_a), 32'(m_err));
      chk("wrapped", 32'(wrapped_a), 32'(m_wrap10));
      chk("wrapped_w4", 32'(wrapped_b), 32'(m_wrap4));
      chk("im_addr", 32'(im_addr_a), 32'(m_a10));
      chk("im_addr_w4", 32'(im_addr_b), 32'(m_a4));
      chk("inst_count", 32'(inst_count_a), 32'((m_cnt > 1023) ? 1023 : m_cnt));
      chk("inst_count_w4", 32'(inst_count_b), 32'((m_cnt > 15) ? 15 : m_cnt));
      if (exp_we) begin
        chk("im_wdata", im_wdata_a, exp_q[0]);
        chk("im_wdata_w4", im_wdata_b, exp_q[0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int f3,
                      input int f7b5, input logic [31:0] imm, input bit last);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_f7b5 = 1'(f7b5); in_imm = imm; in_last = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) chk("send_handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'(done_a), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready_a) | 32'(in_ready_b), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we_a) | 32'(im_we_b), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr_a) | 32'(im_addr_b), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata_a | im_wdata_b, 32'd0);
    chk({tag, "_busy_done"}, 32'({busy_a, done_a, busy_b, done_b}), 32'd0);
    chk({tag, "_err_wrapped"}, 32'({err_a, wrapped_a, err_b, wrapped_b}), 32'd0);
    chk({tag, "_inst_count"}, 32'(inst_count_a) | 32'(inst_count_b), 32'd0);
  endtask

  logic [31:0] prog_words [6] = '{32'h00500093, 32'h002081B3, 32'h0020A423,
                                  32'hFE000EE3, 32'h008000EF, 32'h123452B7};
  int b_op  [14] = '{1, 1, 4, 4, 4, 5, 5, 5, 1, 1, 2, 6, 3, 8};
  int b_f3  [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0};
  int b_imm [14] = '{-2048, 2047, 4094, -4096, 4095, (1 << 20) - 2, -(1 << 20), (1 << 20),
                     31, 32, 2048, -2049, -2048, 32'h7FFFF000};
  int bnd   [15] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 31, 32,
                     -(1 << 20), (1 << 20) - 2, (1 << 20), -(1 << 20) - 2};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known program, with a 3-cycle memory stall after the store.
    do_start();
    send(1, 1, 0, 0, 0, 0, 32'd5, 0);
    send(0, 3, 1, 2, 0, 0, 32'd0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("count_after_two", 32'(inst_count_a), 32'd2);
    @(posedge clk);
    #1;
    send(3, 0, 1, 2, 0, 0, 32'd8, 0);
    stall_en = 1'b1;
    in_valid = 1'b1; in_op = 4'd4; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_imm = 32'hFFFF_FFFC;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready_a), 32'd0);
      chk("stall_we", 32'(im_we_a), 32'd1);
      chk("stall_addr", 32'(im_addr_a), 32'h008);
      chk("stall_wdata", im_wdata_a, 32'h0020A423);
      @(posedge clk);
      #1;
    end
    stall_en = 1'b0;
    send(4, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    send(5, 1, 0, 0, 0, 0, 32'd8, 0);
    send(7, 5, 0, 0, 0, 0, 32'h1234_5000, 1);
    wait_done(50);
    chk("prog_count", 32'(inst_count_a), 32'd6);
    chk("prog_count_w4", 32'(inst_count_b), 32'd6);
    chk("prog_wrapped", 32'(wrapped_a), 32'd0);
    chk("prog_wrapped_w4", 32'(wrapped_b), 32'd1);
    chk("prog_log_size", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        chk("prog_word", log_q[i].w, prog_words[i]);
        chk("prog_addr", 32'(log_q[i].a10), 32'(4 * i));
        chk("prog_addr_w4", 32'(log_q[i].a4), 32'((4 * i) % 16));
      end
    end

    // Rejected descriptors leave no trace besides err.
    do_start();
    send(1, 1, 0, 0, 0, 0, 32'd2048, 0);
    send(12, 1, 2, 3, 0, 0, 32'd0, 0);
    send(1, 2, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
    wait_done(50);
    chk("rej_err", 32'(err_a), 32'd1);
    chk("rej_log_size", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("rej_word", log_q[0].w, 32'hFFF00113);
      chk("rej_addr", 32'(log_q[0].a10), 32'd0);
    end

    // Rejected last descriptor with nothing pending: DONE on that edge.
    do_start();
    send(12, 0, 0, 0, 0, 0, 32'd0, 1);
    @(negedge clk);
    chk("rej_last_done", 32'(done_a), 32'd1);
    chk("rej_last_count", 32'(inst_count_a), 32'd0);
    @(posedge clk);
    #1;

    // Immediate range boundaries.
    do_start();
    for (int i = 0; i < 14; i++)
      send(b_op[i], 3, 4, 5, b_f3[i], (i == 9) ? 1 : 0, 32'(b_imm[i]), i == 13);
    wait_done(50);
    chk("bound_log_size", 32'(log_q.size()), 32'd9);
    chk("bound_err", 32'(err_a), 32'd1);

    // Randomized stream with random memory back-pressure.
    do_start();
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [31:0] imm;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0: imm = 32'(int'($urandom_range(0, 63)) - 32);
        1: imm = 32'(bnd[$urandom_range(0, 14)]);
        2: imm = $urandom;
        default: imm = 32'(int'($urandom_range(0, 8190)) - 4096) & 32'hFFFF_FFFE;
      endcase
      send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), imm, i == 299);
    end
    wait_done(200);
    ready_mode = 0;
    chk("rand_count_w4_sat", 32'(inst_count_b), 32'((m_cnt > 15) ? 15 : m_cnt));

    // Reset during a stalled write clears everything at once.
    do_start();
    send(0, 1, 2, 3, 0, 1, 32'd0, 0);
    stall_en = 1'b1;
    @(negedge clk);
    chk("pre_rst_we", 32'(im_we_a), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_inst_encoder.md
# rv32i_inst_encoder

Streaming RV32I instruction encoder and instruction-memory loader; the encode-side counterpart of the pipeline's opcode-to-control decoder. Accepts abstract instruction descriptors (class, registers, funct bits, raw immediate) over a valid/ready handshake. Packs each descriptor into a 32-bit RV32I word with range-checked immediates. Writes accepted words to sequential instruction-memory addresses through a stallable write port. Used by the bench and boot path to load programs before the core is released from reset.

## Interface
- ADDR_W, 10: width of the byte address to instruction memory.
- BASE_ADDR, 0: first byte address written after `start`; multiple of 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; reloads the address to BASE_ADDR, clears counters and flags, enters RUN.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_op  in  4  class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 (ignored for JAL/LUI/AUIPC; forced 010 for LW/SW, 000 for JALR).
- in_f7b5  in  1  instruction bit 30 for R-type and I-ALU shifts.
- in_imm  in  32  raw signed immediate; for LUI/AUIPC, the value of bits 31:12.
- in_last  in  1  final descriptor of the program.
- im_we  out  1  write request.
- im_ready  in  1  memory accepts the write when im_we && im_ready.
- im_addr  out  ADDR_W  byte address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- err  out  1  sticky; at least one descriptor was rejected.
- wrapped  out  1  sticky; the address wrapped modulo 2^ADDR_W.
- inst_count  out  ADDR_W  number of words written since `start`.

## Operation
- States:
  - IDLE: reset state; in_ready=0; start -> RUN.
  - RUN: accepts descriptors; goes to DONE when the last descriptor is accepted and no write is pending. If the last descriptor is legal, that means when its write completes.
  - DONE: in_ready=0, im_we=0; start -> RUN.
  - start in any state -> RUN, clears counters/flags, and discards any pending write.
- Encode (stage 1): standard RV32I R/I/S/B/U/J packing using the opcode constants shared with the control decoder.
- Legality checks:
  - I, S, LW, JALR: -2048 ≤ imm ≤ 2047.
  - B: -4096 ≤ imm ≤ 4094 and imm[0]=0.
  - J: -2^20 ≤ imm ≤ 2^20-2 and imm[0]=0.
  - I-ALU shifts (funct3 001/101): imm[11:5]=0.
  - LUI/AUIPC: imm[11:0] ignored.
  - Illegal in_op or a failed check: the descriptor is consumed, nothing is written, err is set, and the address does not advance.
- Output register (stage 2): holds one word. im_we stays asserted with stable addr/wdata until im_ready.
- Address/count on each completed write:
  - im_addr += 4, wrapping modulo 2^ADDR_W.
  - A wrap to 0 sets wrapped.
  - inst_count += 1, saturating at all-ones.
- Reset values: in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, busy=0, done=0, err=0, wrapped=0, inst_count=0.

## Timing
- Latency: descriptor accepted at edge N -> im_we=1 with its word during cycle N+1.
- Throughput: 1 word/cycle while im_ready=1.
- in_ready = (state==RUN) && !last_seen && (!im_we || im_ready). This is a combinational path from im_ready; no skid buffer.
- Accept and write completion in the same cycle: the output register reloads with no bubble.
- in_last on a rejected descriptor: DONE on the next edge if no write is pending, otherwise after the pending write completes.
- rst asserted mid-write: im_we drops immediately (asynchronous); the pending word is lost.

## Structure
- rv32i_pkg holds:
  - opcode localparams shared with the control decoder (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - in_op class codes;
  - state encoding.
- Sub-module rv32i_imm_pack: combinational; takes op, rd, rs1, rs2, funct3, f7b5 and imm, and returns {word, legal}.
- The top level holds the FSM, output register, address counter and flags.

## Test plan
- start; send I-ALU rd=1 rs1=0 f3=0 imm=5, then R rd=3 rs1=1 rs2=2 f3=0 f7b5=0 -> writes 0x00500093 @0x000, 0x002081B3 @0x004; inst_count=2.
- Send SW rs1=1 rs2=2 imm=8, BRANCH f3=0 rs1=rs2=0 imm=-4, JAL rd=1 imm=8, LUI rd=5 imm=0x12345000 with in_last on the LUI -> 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7 at consecutive addresses; done=1.
- Hold im_ready=0 for 3 cycles mid-stream -> im_addr/im_wdata stable, in_ready=0, no descriptor lost or duplicated.
- I-ALU imm=2048, then in_op=12, then a legal descriptor -> err=1, both rejected descriptors unwritten, legal word at BASE_ADDR.
- ADDR_W=4: write 5 words -> 5th at 0x0, wrapped=1; assert rst during an im_we stall -> all outputs at reset values immediately.
